// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port 8-bit SRAM among NUM_REQ requesters.
// Grants one command per cycle, registers it onto the SRAM port, and returns
// read data to the issuing requester two cycles after the handshake.
module sram_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_BITS = 19,
  parameter int MEM_DEPTH = 380000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQ*8-1:0]           req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [7:0]                     rsp_data,
  output logic                           err_oob,
  output logic                           mem_we,
  output logic [ADDR_BITS-1:0]           mem_addr,
  output logic [7:0]                     mem_data_in,
  input  logic [7:0]                     mem_data_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so MEM_DEPTH == 2**ADDR_BITS still compares correctly.
  localparam logic [ADDR_BITS:0] DEPTH = (ADDR_BITS+1)'(MEM_DEPTH);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             oob;
  } tag_t;

  logic [NUM_REQ-1:0][ADDR_BITS-1:0] addr_a;
  logic [NUM_REQ-1:0][7:0]           wdata_a;
  logic [IDX_W-1:0]                  ptr, gidx;
  logic                              found, g_we, g_oob;
  logic [ADDR_BITS-1:0]              g_addr;
  logic [7:0]                        g_wdata;
  logic                              rd0;
  logic [2:1]                        vld_pipe;
  tag_t                              tag0, tag1, tag2;

  assign addr_a  = req_addr;
  assign wdata_a = req_wdata;

  // Requester index k+1 positions after the last grant, wrapping.
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] p, input int k);
    int s;
    s = (int'(p) + k + 1) % NUM_REQ;
    return s[IDX_W-1:0];
  endfunction

  // Pick the first valid requester in round-robin order after the last grant.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[rr_idx(ptr, k)]) begin
        found = 1'b1;
        gidx  = rr_idx(ptr, k);
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
    assign req_ready[i] = found && (gidx == IDX_W'(i));
  end

  // A grant always coincides with a handshake since ready implies valid.
  assign g_addr  = addr_a[gidx];
  assign g_wdata = wdata_a[gidx];
  assign g_we    = req_we[gidx];
  assign g_oob   = ({1'b0, g_addr} >= DEPTH);
  assign rd0     = found && !g_we;
  assign tag0    = '{idx: gidx, oob: g_oob};

  // Pointer remembers the last granted requester; reset makes requester 0 next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ptr <= IDX_W'(NUM_REQ - 1);
    else if (found) ptr <= gidx;
  end

  // Command stage: register the granted command onto the SRAM port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      err_oob     <= 1'b0;
    end else begin
      mem_we  <= found && g_we && !g_oob;
      err_oob <= found && g_oob;
      if (found) begin
        mem_addr    <= g_addr;
        mem_data_in <= g_wdata;
      end
    end
  end

  // Read tag pipeline: stage 1 tracks the command, stage 2 the SRAM output cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      tag1     <= '0;
      tag2     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], rd0};
      tag1     <= tag0;
      tag2     <= tag1;
    end
  end

  // Steer SRAM read data to the issuing requester; zero when idle or out of range.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (vld_pipe[2]) begin
      rsp_valid[tag2.idx] = 1'b1;
      rsp_data            = tag2.oob ? 8'h00 : mem_data_out;
    end
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter with a 1-cycle registered SRAM model.
module tb_sram_rr_arbiter;
  localparam int N  = 4;
  localparam int AB = 19;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_we = '0;
  logic [N*AB-1:0]   req_addr = '0;
  logic [N*8-1:0]    req_wdata = '0;
  logic [N-1:0]      req_ready, rsp_valid;
  logic [7:0]        rsp_data, mem_data_in, mem_data_out;
  logic              err_oob, mem_we;
  logic [AB-1:0]     mem_addr;

  // SRAM model plus a preload port so only one process writes the array.
  logic [7:0]        mem [0:(1<<AB)-1];
  logic              pl_en = 1'b0;
  logic [AB-1:0]     pl_addr = '0;
  logic [7:0]        pl_data = '0;

  int total = 0;
  int bad   = 0;

  sram_rr_arbiter #(.NUM_REQ(N), .ADDR_BITS(AB), .MEM_DEPTH(380000)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err_oob(err_oob),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Registered-read single-port SRAM.
  always @(posedge clk) begin
    if (pl_en)       mem[pl_addr] <= pl_data;
    else if (mem_we) mem[mem_addr] <= mem_data_in;
    mem_data_out <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic we, input logic [AB-1:0] a, input logic [7:0] d);
    req_valid[i]          = 1'b1;
    req_we[i]             = we;
    req_addr[i*AB +: AB]  = a;
    req_wdata[i*8 +: 8]   = d;
  endtask

  task automatic preload(input logic [AB-1:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state and preload (memory writes happen while the DUT is in reset).
    rst_n = 1'b0;
    preload(19'd100, 8'h5A);
    preload(19'd10, 8'h01);
    preload(19'd11, 8'h02);
    preload(19'd12, 8'h03);
    preload(19'd13, 8'h04);
    preload(19'd380000, 8'hEE);
    preload(19'd0, 8'h77);
    smp();
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_din", 32'(mem_data_in), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_err", 32'(err_oob), 0);
    tick();
    rst_n = 1'b1;

    // Single read by requester 2.
    set_req(2, 1'b0, 19'd100, 8'h00);
    smp(); chk("rd1_ready", 32'(req_ready), 32'h4); chk("rd1_rsp_T", 32'(rsp_valid), 0);
    tick(); req_valid = '0;
    smp(); chk("rd1_rsp_T1", 32'(rsp_valid), 0); chk("rd1_addr", 32'(mem_addr), 100);
    chk("rd1_we", 32'(mem_we), 0);
    tick();
    smp(); chk("rd1_rsp_T2", 32'(rsp_valid), 32'h4); chk("rd1_data", 32'(rsp_data), 32'h5A);
    tick();
    smp(); chk("rd1_rsp_T3", 32'(rsp_valid), 0); chk("rd1_data_idle", 32'(rsp_data), 0);

    // Fairness: everyone valid for 8 cycles after a fresh reset.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 19'd0, 8'h00);
    for (int c = 0; c < 8; c++) begin
      smp(); chk($sformatf("fair_ready%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
      tick();
    end
    req_valid = '0;
    tick(); tick(); tick();

    // Write then read of the last valid address.
    do_reset();
    set_req(1, 1'b1, 19'd379999, 8'hC3);
    smp(); chk("wr_ready", 32'(req_ready), 32'h2);
    tick(); req_valid = '0;
    set_req(3, 1'b0, 19'd379999, 8'h00);
    smp(); chk("wr_mem_we", 32'(mem_we), 1); chk("wr_mem_addr", 32'(mem_addr), 379999);
    chk("wr_mem_din", 32'(mem_data_in), 32'hC3); chk("rd3_ready", 32'(req_ready), 32'h8);
    chk("wr_err", 32'(err_oob), 0);
    tick(); req_valid = '0;
    smp(); chk("rd3_rsp_T1", 32'(rsp_valid), 0);
    tick();
    smp(); chk("rd3_rsp", 32'(rsp_valid), 32'h8); chk("rd3_data", 32'(rsp_data), 32'hC3);
    tick();

    // Out-of-range write then read by requester 0.
    set_req(0, 1'b1, 19'd380000, 8'hFF);
    smp(); chk("oobw_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = '0;
    smp(); chk("oobw_we", 32'(mem_we), 0); chk("oobw_err", 32'(err_oob), 1);
    tick();
    smp(); chk("oobw_err_end", 32'(err_oob), 0); chk("oobw_rsp", 32'(rsp_valid), 0);
    set_req(0, 1'b0, 19'd380000, 8'h00);
    smp(); chk("oobr_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = '0;
    smp(); chk("oobr_err", 32'(err_oob), 1);
    tick();
    smp(); chk("oobr_err_end", 32'(err_oob), 0); chk("oobr_rsp", 32'(rsp_valid), 32'h1);
    chk("oobr_data", 32'(rsp_data), 0);
    tick();

    // Pipelined reads from all four requesters.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 19'(10 + i), 8'h00);
    for (int c = 0; c < 6; c++) begin
      smp();
      if (c < 4) chk($sformatf("pipe_ready%0d", c), 32'(req_ready), 32'(1 << c));
      else       chk($sformatf("pipe_ready%0d", c), 32'(req_ready), 0);
      if (c >= 2) begin
        chk($sformatf("pipe_rsp%0d", c), 32'(rsp_valid), 32'(1 << (c - 2)));
        chk($sformatf("pipe_data%0d", c), 32'(rsp_data), 32'(c - 1));
      end else begin
        chk($sformatf("pipe_rsp%0d", c), 32'(rsp_valid), 0);
      end
      tick();
      if (c < 4) req_valid[c] = 1'b0;
    end

    // Reset one cycle after a read grant: the response must never appear.
    set_req(2, 1'b0, 19'd100, 8'h00);
    smp(); chk("mid_ready", 32'(req_ready), 32'h4);
    tick(); req_valid = '0;
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      smp(); chk($sformatf("mid_rst_rsp%0d", c), 32'(rsp_valid), 0);
      tick();
    end
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      smp(); chk($sformatf("mid_post_rsp%0d", c), 32'(rsp_valid), 0);
      tick();
    end
    set_req(1, 1'b0, 19'd11, 8'h00);
    set_req(0, 1'b0, 19'd10, 8'h00);
    smp(); chk("post_rst_ready", 32'(req_ready), 32'h1);
    tick(); req_valid = '0;
    tick();
    smp(); chk("post_rst_rsp", 32'(rsp_valid), 32'h1); chk("post_rst_data", 32'(rsp_data), 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
